// File: rtl/ramdisk_pkg.sv
// ramdisk_pkg: state encoding and default partition geometry shared by the ramdisk arbiter.
package ramdisk_pkg;
   typedef enum logic [2:0] {IDLE, CHECK, ISSUE, XFER, RELEASE} state_t;
   localparam int unsigned BLOCK_WORDS = 256;
   localparam int unsigned DEF_BASE0   = 0;
   localparam int unsigned DEF_BASE1   = 262144;
   localparam int unsigned DEF_SIZE0   = 262144;
   localparam int unsigned DEF_SIZE1   = 262144;
endpackage

// File: rtl/ramdisk_rr_pick.sv
// ramdisk_rr_pick: 2-way requester pick; round-robin, or fixed priority to requester 0
// when RAMDISK_ARB_PRIORITY_EN is defined.
module ramdisk_rr_pick (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       pick_o
);
`ifdef RAMDISK_ARB_PRIORITY_EN
   logic unused_last;
   assign unused_last = last_i;
   assign pick_o = ~req_i[0];
`else
   // on a tie the requester that was not granted last wins
   assign pick_o = &req_i ? ~last_i : req_i[1];
`endif
endmodule

// File: rtl/ramdisk_arbiter.sv
// ramdisk_arbiter: shares one ramdisk command port between two partitioned requesters.
// RAMDISK_ARB_PRIORITY_EN selects fixed priority (requester 0) instead of round-robin.
module ramdisk_arbiter
   import ramdisk_pkg::*;
#(
   parameter int unsigned BASE0 = DEF_BASE0,
   parameter int unsigned BASE1 = DEF_BASE1,
   parameter int unsigned SIZE0 = DEF_SIZE0,
   parameter int unsigned SIZE1 = DEF_SIZE1
) (
   input  logic        ui_clk,
   input  logic        reset,
   input  logic [1:0]  rq_read_cmd,
   input  logic [1:0]  rq_write_cmd,
   input  logic [63:0] rq_block_address,
   output logic [1:0]  rq_command_ready,
   input  logic [31:0] rq_write_data,
   output logic [1:0]  rq_write_data_enable,
   output logic [15:0] rq_read_data,
   output logic [1:0]  rq_read_data_enable,
   output logic [1:0]  rq_error,
   input  logic        command_ready,
   output logic        read_cmd,
   output logic        write_cmd,
   output logic [31:0] block_address,
   output logic [15:0] write_data,
   input  logic        write_data_enable,
   input  logic [15:0] read_data,
   input  logic        read_data_enable,
   output logic        grant,
   output logic        busy
);
   state_t      state_q, state_d;
   logic        grant_q, grant_d, last_q, last_d, wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  err_q, err_d;
   logic [1:0]  req;
   logic        pick, g_rd, g_wr, in_range, idle, route;
   logic [31:0] g_addr;

   assign req      = rq_read_cmd | rq_write_cmd;
   assign g_rd     = rq_read_cmd[grant_q];
   assign g_wr     = rq_write_cmd[grant_q];
   assign g_addr   = grant_q ? rq_block_address[63:32] : rq_block_address[31:0];
   assign in_range = g_addr < (grant_q ? SIZE1 : SIZE0);

   ramdisk_rr_pick u_pick (.req_i(req), .last_i(last_q), .pick_o(pick));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      err_d   = '0;
      case (state_q)
         IDLE: if (command_ready && |req) begin
            grant_d = pick;
            state_d = CHECK;
         end
         CHECK: begin
            addr_d = (grant_q ? BASE1 : BASE0) + g_addr;
            wr_d   = g_wr;
            if (!in_range || (g_rd && g_wr)) begin
               err_d[grant_q] = 1'b1;
               state_d        = RELEASE;
            end else begin
               // a request withdrawn before CHECK is released without issuing
               state_d = (g_rd || g_wr) ? ISSUE : RELEASE;
            end
         end
         ISSUE:   if (!command_ready) state_d = XFER;
         XFER:    if (command_ready) state_d = RELEASE;
         RELEASE: if (!g_rd && !g_wr) begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ui_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   assign idle  = state_q == IDLE;
   assign busy  = !idle;
   assign route = state_q inside {ISSUE, XFER, RELEASE};

   assign read_cmd      = (state_q == ISSUE) && !wr_q;
   assign write_cmd     = (state_q == ISSUE) && wr_q;
   assign block_address = addr_q;
   assign grant         = grant_q;
   assign rq_error      = err_q;

   assign rq_command_ready[0] = idle && command_ready && !(req[1] && pick);
   assign rq_command_ready[1] = idle && command_ready && !(req[0] && !pick);

   assign write_data           = grant_q ? rq_write_data[31:16] : rq_write_data[15:0];
   assign rq_read_data         = read_data;
   assign rq_write_data_enable = (route && write_data_enable) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign rq_read_data_enable  = (route && read_data_enable) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_ramdisk_arbiter.sv
// tb_ramdisk_arbiter: directed scoreboard bench for ramdisk_arbiter acting as the downstream ramdisk.
module tb_ramdisk_arbiter;
   logic        ui_clk = 1'b0, reset = 1'b1;
   logic [1:0]  rq_read_cmd = '0, rq_write_cmd = '0;
   logic [63:0] rq_block_address = '0;
   logic [1:0]  rq_command_ready;
   logic [31:0] rq_write_data = '0;
   logic [1:0]  rq_write_data_enable;
   logic [15:0] rq_read_data;
   logic [1:0]  rq_read_data_enable;
   logic [1:0]  rq_error;
   logic        command_ready = 1'b1;
   logic        read_cmd, write_cmd;
   logic [31:0] block_address;
   logic [15:0] write_data;
   logic        write_data_enable = 1'b0;
   logic [15:0] read_data = '0;
   logic        read_data_enable = 1'b0;
   logic        grant, busy;

   typedef struct {
      int          g;
      bit          w;
      logic [31:0] a;
      logic [15:0] wd;
   } exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0;

   ramdisk_arbiter dut (
      .ui_clk(ui_clk), .reset(reset), .rq_read_cmd(rq_read_cmd), .rq_write_cmd(rq_write_cmd),
      .rq_block_address(rq_block_address), .rq_command_ready(rq_command_ready),
      .rq_write_data(rq_write_data), .rq_write_data_enable(rq_write_data_enable),
      .rq_read_data(rq_read_data), .rq_read_data_enable(rq_read_data_enable),
      .rq_error(rq_error), .command_ready(command_ready), .read_cmd(read_cmd),
      .write_cmd(write_cmd), .block_address(block_address), .write_data(write_data),
      .write_data_enable(write_data_enable), .read_data(read_data),
      .read_data_enable(read_data_enable), .grant(grant), .busy(busy)
   );

   always #5 ui_clk = ~ui_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int g, input bit rd, input bit wr, input logic [31:0] a, input logic [15:0] wd);
      rq_read_cmd[g]             = rd;
      rq_write_cmd[g]            = wr;
      rq_block_address[g*32 +: 32] = a;
      rq_write_data[g*16 +: 16]  = wd;
   endtask

   task automatic post(input int g, input bit w, input logic [31:0] a, input logic [15:0] wd);
      drive(g, !w, w, a, wd);
      sb.push_back('{g, w, (g == 1) ? 32'd262144 + a : a, wd});
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 20) begin
         @(negedge ui_clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   // Play the downstream ramdisk for one granted command and check it against the scoreboard.
   task automatic serve(input int n);
      exp_t e;
      int   w = 0, hit = 0, miss = 0;
      logic [15:0] rd_val;
      while (!(read_cmd || write_cmd) && w < 20) begin
         @(negedge ui_clk);
         w++;
      end
      chk("issue_seen", read_cmd || write_cmd, 1);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("grant", grant, e.g);
      chk("block_address", block_address, e.a);
      chk("cmd", {write_cmd, read_cmd}, e.w ? 2'b10 : 2'b01);
      rq_read_cmd[e.g]  = 1'b0;
      rq_write_cmd[e.g] = 1'b0;
      repeat (2) @(negedge ui_clk);
      chk("cmd_held", {write_cmd, read_cmd}, e.w ? 2'b10 : 2'b01);
      command_ready = 1'b0;
      @(negedge ui_clk);
      chk("cmd_drop", {write_cmd, read_cmd}, 0);
      for (int i = 0; i < n; i++) begin
         rd_val = 16'(i * 3 + 1);
         if (e.w) write_data_enable = 1'b1;
         else begin
            read_data_enable = 1'b1;
            read_data        = rd_val;
         end
         #1;
         hit  += e.w ? int'(rq_write_data_enable[e.g]) : int'(rq_read_data_enable[e.g]);
         miss += e.w ? int'(rq_write_data_enable[1-e.g]) : int'(rq_read_data_enable[1-e.g]);
         if (i == 0 || i == n - 1) begin
            if (e.w) chk("wr_data", write_data, e.wd);
            else chk("rd_data", rq_read_data, rd_val);
         end
         @(negedge ui_clk);
      end
      write_data_enable = 1'b0;
      read_data_enable  = 1'b0;
      chk("strobes_hit", hit, n);
      chk("strobes_miss", miss, 0);
      command_ready = 1'b1;
      wait_idle("released");
   endtask

   task automatic expect_error(input logic [1:0] mask);
      logic       seen = 1'b0;
      int         pulses = 0;
      logic [1:0] ev = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge ui_clk);
         seen |= read_cmd | write_cmd;
         if (rq_error != 0) begin
            pulses++;
            ev = rq_error;
         end
      end
      chk("err_no_cmd", seen, 0);
      chk("err_pulses", pulses, 1);
      chk("err_value", ev, mask);
      rq_read_cmd  = '0;
      rq_write_cmd = '0;
      wait_idle("err_released");
   endtask

   initial begin
      int w;
      repeat (2) @(negedge ui_clk);
      reset = 1'b0;
      @(negedge ui_clk);
      chk("rst_cmds", {write_cmd, read_cmd}, 0);
      chk("rst_block_address", block_address, 0);
      chk("rst_error", rq_error, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rdy_noreq", rq_command_ready, 2'b11);

      // simultaneous reads right after reset: requester 0 wins the first tie
      post(0, 0, 32'd3, 16'h0);
      post(1, 0, 32'd9, 16'h0);
      #1 chk("rdy_tie", rq_command_ready, 2'b01);
      serve(4);
      serve(4);

      post(0, 0, 32'd5, 16'h0);
      serve(256);

      post(1, 1, 32'd7, 16'hBEEF);
      rq_write_data[15:0] = 16'h1234;
      #1 chk("rdy_req1_only", rq_command_ready, 2'b10);
      serve(8);

      post(0, 0, 32'd262143, 16'h0);
      serve(1);

      drive(0, 1, 0, 32'd262144, 16'h0);
      expect_error(2'b01);
      drive(1, 1, 1, 32'd1, 16'h0);
      expect_error(2'b10);

      // strobes with no owner are dropped; read data is still broadcast
      read_data         = 16'hA5A5;
      read_data_enable  = 1'b1;
      write_data_enable = 1'b1;
      #1;
      chk("idle_rd_drop", rq_read_data_enable, 0);
      chk("idle_wr_drop", rq_write_data_enable, 0);
      chk("rd_broadcast", rq_read_data, 16'hA5A5);
      read_data_enable  = 1'b0;
      write_data_enable = 1'b0;

      drive(0, 1, 0, 32'd1, 16'h0);
      w = 0;
      while (!read_cmd && w < 20) begin
         @(negedge ui_clk);
         w++;
      end
      chk("mid_issue", read_cmd, 1);
      command_ready = 1'b0;
      @(negedge ui_clk);
      chk("mid_xfer_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmds", {write_cmd, read_cmd}, 0);
      chk("mid_rst_grant", grant, 0);
      @(negedge ui_clk);
      reset         = 1'b0;
      command_ready = 1'b1;
      rq_read_cmd   = '0;
      @(negedge ui_clk);

`ifdef RAMDISK_ARB_PRIORITY_EN
      drive(1, 1, 0, 32'd2, 16'h0);
      for (int k = 0; k < 3; k++) begin
         post(0, 0, 32'(k + 10), 16'h0);
         serve(2);
      end
      sb.push_back('{1, 1'b0, 32'd262146, 16'h0});
      serve(2);
`endif

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ramdisk_arbiter.md
RAMDISK_ARBITER -- requirements
Module: ramdisk_arbiter

Interface
REQ-001 SHALL have parameter BASE0, default 0: block-address offset added for requester 0.
REQ-002 SHALL have parameter BASE1, default 262144: block-address offset added for requester 1.
REQ-003 SHALL have parameter SIZE0, default 262144: block count of partition 0.
REQ-004 SHALL have parameter SIZE1, default 262144: block count of partition 1.
REQ-005 SHALL have ports as follows:
- ui_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- rq_read_cmd  in  2  per-requester read request, level.
- rq_write_cmd  in  2  per-requester write request, level.
- rq_block_address  in  64  [31:0] requester 0, [63:32] requester 1.
- rq_command_ready  out  2  per-requester ready.
- rq_write_data  in  32  [15:0] requester 0, [31:16] requester 1.
- rq_write_data_enable  out  2  routed write-FIFO pop.
- rq_read_data  out  16  read data, broadcast to both requesters.
- rq_read_data_enable  out  2  routed read strobe.
- rq_error  out  2  one-cycle error pulse.
- command_ready  in  1  downstream ramdisk idle.
- read_cmd  out  1  downstream read.
- write_cmd  out  1  downstream write.
- block_address  out  32  downstream block address.
- write_data  out  16  downstream write data.
- write_data_enable  in  1  downstream write pop.
- read_data  in  16  downstream read data.
- read_data_enable  in  1  downstream read strobe.
- grant  out  1  index of the owning requester.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-006 SHALL implement states IDLE, CHECK, ISSUE, XFER and RELEASE.
REQ-007 IDLE: when command_ready=1 and any requester has a command, SHALL register grant and go to CHECK.
REQ-008 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset the last-granted pointer is 1, so requester 0 wins the first tie.
REQ-009 CHECK (exactly one cycle): address SHALL be in range iff rq_block_address < SIZEn, compared unsigned on 32 bits; block_address SHALL be registered as BASEn plus address, truncated to 32 bits.
REQ-010 CHECK: if the address is out of range, or both read and write are asserted, SHALL pulse rq_error[grant] for one cycle and go to RELEASE without issuing.
REQ-011 ISSUE: SHALL hold read_cmd or write_cmd high (matching the request) until command_ready=0 is sampled, then drop it and go to XFER.
REQ-012 XFER: SHALL wait for command_ready=1, then go to RELEASE.
REQ-013 RELEASE: SHALL wait until both rq_read_cmd[grant] and rq_write_cmd[grant] are 0, then update the last-granted pointer and go to IDLE.
REQ-014 rq_command_ready[i] SHALL equal (state==IDLE) & command_ready & ~(busy request pending from the other requester with priority).
REQ-015 Routing SHALL be combinational:
- write_data = rq_write_data slice selected by grant.
- rq_write_data_enable[grant] = write_data_enable; the other bit is 0.
- rq_read_data = read_data.
- rq_read_data_enable[grant] = read_data_enable; the other bit is 0.
REQ-016 A strobe from write_data_enable or read_data_enable arriving in IDLE or CHECK SHALL be dropped and not routed.
REQ-017 A requester dropping its command during ISSUE or XFER SHALL NOT abort the transfer, which completes normally.

Reset
REQ-018 On reset SHALL enter IDLE immediately, including mid-transfer.
REQ-019 Reset values SHALL be: read_cmd=0, write_cmd=0, block_address=0, rq_error=0, grant=0, busy=0, last-granted pointer=1.

Configuration
REQ-020 With RAMDISK_ARB_PRIORITY_EN defined, arbitration SHALL be fixed priority with requester 0 always winning; the pointer is unused.
REQ-021 Without RAMDISK_ARB_PRIORITY_EN, arbitration SHALL be round-robin per REQ-008.

Structure
REQ-022 Shared package ramdisk_pkg SHALL hold the state encoding and the constants BLOCK_WORDS=256 and the default BASE/SIZE values.
REQ-023 Sub-module ramdisk_rr_pick SHALL implement the 2-way round-robin/priority pick.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Req0 read, address 5 -> block_address=5, read_cmd held until command_ready=0, 256 read strobes routed only to bit 0.
- Req1 write, address 7 -> block_address=262151, rq_write_data[31:16] forwarded to write_data.
- Both requesters issue a read in the same cycle after reset -> requester 0 served first, then requester 1.
- Req0 address 262144 -> one-cycle rq_error[0] pulse, read_cmd and write_cmd never asserted.
- Reset asserted mid-XFER -> busy=0, read_cmd=0 and write_cmd=0 immediately.
- With RAMDISK_ARB_PRIORITY_EN, requester 0 continuously requesting -> requester 1 never granted.
